line_buffer_2: RTL and testbench
================================

// Module: line_buffer_2
// PURPOSE
//  Two-row line buffer for the CNN datapath: stores the last two image rows of a
//  raster-scanned pixel stream and outputs, per accepted pixel, the same-column
//  pixel of the previous row (d_out1) and of the row before that (d_out2).
//  The caller combines d_in, d_out1 and d_out2 into a 3-row column for the
//  window/convolution stage that follows.
// PARAMETERS
//  DATA_W  32  width of one pixel/sample word
//  LINE_W  28  pixels per image row (delay length of each row stage), >= 2
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst_n      in   1       reset; asynchronous, active-high (1 = reset)
//  d_in       in   DATA_W  incoming pixel, sampled when in_valid=1
//  in_valid   in   1       d_in qualifier; buffer advances only on valid beats
//  d_out1     out  DATA_W  pixel accepted LINE_W valid beats earlier
//  d_out2     out  DATA_W  pixel accepted 2*LINE_W valid beats earlier
//  out_valid  out  1       d_out1/d_out2 hold a valid column pair this cycle
// BEHAVIOUR
//  - Reset (async assert, release on clk): d_out1=0, d_out2=0, out_valid=0,
//    column pointer=0, fill count=0. RAM contents not cleared.
//  - Storage: two circular arrays row1[LINE_W], row2[LINE_W], shared pointer ptr.
//  - On rising edge with in_valid=1 (beat n, n counted from reset):
//      d_out1 <= row1[ptr]; d_out2 <= row2[ptr];
//      row2[ptr] <= row1[ptr]; row1[ptr] <= d_in;
//      ptr <= (ptr==LINE_W-1) ? 0 : ptr+1;
//      cnt <= min(cnt+1, 2*LINE_W)   (saturating, no wrap)
//      out_valid <= (cnt == 2*LINE_W)  (pre-increment value)
//  - Result: on beat n, one cycle later d_out1 = sample n-LINE_W,
//    d_out2 = sample n-2*LINE_W; out_valid first asserts for n = 2*LINE_W.
//  - On rising edge with in_valid=0: ptr, cnt, RAM unchanged; d_out1/d_out2
//    hold last value; out_valid <= 0. Gaps of any length are transparent.
//  - Latency: fixed 1 clock from valid input beat to registered outputs.
//  - out_valid is a 1-cycle qualifier per valid beat; no back-pressure.
//  - Wrap-around: ptr wraps LINE_W-1 -> 0 with no bubble; rows are implicit,
//    no row/frame markers are tracked.
//  - Reset mid-stream: pointer and fill count return to 0; out_valid stays 0
//    until 2*LINE_W further valid beats; stale RAM data never flagged valid.
//  - Widths: cnt needs clog2(2*LINE_W+1) bits, ptr clog2(LINE_W) bits.
// STRUCTURE
//  - Shared package: DATA_W and LINE_W defaults, pixel word typedef.
//  - Sub-module line_delay (one LINE_W-deep circular delay with own pointer,
//    enable = in_valid, registered output), instantiated twice in cascade;
//    top level holds fill counter and out_valid register. RAM may infer BRAM
//    or distributed RAM; read-before-write on the same address is required.
// TESTING  (LINE_W=4, DATA_W=32, d_in increments 0,1,2,... per valid beat)
//  - Reset held: d_out1=d_out2=0, out_valid=0 regardless of in_valid toggling.
//  - Continuous in_valid: out_valid first 1 the cycle after d_in=8, with
//    d_out1=4, d_out2=0; next cycle d_out1=5, d_out2=1, out_valid=1.
//  - in_valid toggling every cycle (tb pattern): out_valid pulses only after
//    valid beats; on valid beat d_in=k>=8 -> d_out1=k-4, d_out2=k-8.
//  - Long gap (in_valid=0 for 10 cycles mid-row): outputs hold, out_valid=0,
//    next valid beat continues sequence with no skipped/duplicated column.
//  - Reset asserted after 12 beats then released: out_valid=0 until 8 new
//    valid beats accepted; first flagged pair matches post-reset samples.
//  - Steady state 100 beats: every out_valid beat satisfies
//    d_out1 = d_out2 + 4 = (last accepted d_in) - 4.

Source files
------------

// File: rtl/line_buffer_2_pkg.sv
// Shared defaults and the pixel word type for the two-row line buffer.
package line_buffer_2_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int LINE_W_DEF = 28;

   typedef logic [DATA_W_DEF-1:0] pixel_t;

   // The fill counter must be able to hold 2*line_w itself, hence the +1.
   function automatic int cnt_width(input int line_w);
      return $clog2(2 * line_w + 1);
   endfunction

endpackage

// File: rtl/line_buffer_2_line_delay.sv
// One image row of delay: a LINE_W-deep circular buffer that advances only on
// enabled beats. o_tap is the word about to be overwritten (read-before-write),
// which is what a following stage must store; o_q is that word registered.
module line_delay
   import line_buffer_2_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_tap,
   output logic [DATA_W-1:0] o_q
);

   localparam int PTR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_W - 1);

   logic [PTR_W-1:0]  r_ptr;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] r_mem [LINE_W];

   assign o_tap = r_mem[r_ptr];
   assign o_q   = r_q;

   // Pointer and output register; both freeze while the enable is low.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_ptr <= '0;
         r_q   <= '0;
      end else if (i_en) begin
         r_q   <= r_mem[r_ptr];
         r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
      end
   end

   // Storage write; contents are deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (i_en && !rst_n)
         r_mem[r_ptr] <= i_d;
   end

endmodule

// File: rtl/line_buffer_2.sv
// Two-row line buffer: per accepted pixel, presents the same-column pixel of
// the previous row (d_out1) and the row before that (d_out2), one clock later.
// Note: rst_n is active-high despite its name.
module line_buffer_2
   import line_buffer_2_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d_in,
   input  logic              in_valid,
   output logic [DATA_W-1:0] d_out1,
   output logic [DATA_W-1:0] d_out2,
   output logic              out_valid
);

   localparam int CNT_W = cnt_width(LINE_W);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 * LINE_W);

   logic [DATA_W-1:0] w_tap1;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_out_valid;

   // Row stage 1 holds the previous row; its evicted word feeds row stage 2.
   line_delay #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_row1 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (in_valid),
      .i_d   (d_in),
      .o_tap (w_tap1),
      .o_q   (d_out1)
   );

   line_delay #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_row2 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (in_valid),
      .i_d   (w_tap1),
      .o_tap (),
      .o_q   (d_out2)
   );

   // Saturating fill count; outputs are flagged only once both rows hold
   // samples written since the last reset, so stale RAM is never qualified.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid && (r_cnt == CNT_FULL);
         if (in_valid && (r_cnt != CNT_FULL))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_line_buffer_2.sv
// Directed, self-checking bench for line_buffer_2 with LINE_W=4, DATA_W=32.
module tb_line_buffer_2;

   localparam int LW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] d_in = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] d_out1;
   logic [DW-1:0] d_out2;
   logic          out_valid;

   line_buffer_2 #(.DATA_W(DW), .LINE_W(LW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d_in      (d_in),
      .in_valid  (in_valid),
      .d_out1    (d_out1),
      .d_out2    (d_out2),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: sequence value, valid beats since reset (saturating),
   // and the expected held output pair when it is known.
   int            seq = 0;
   int            since_rst = 0;
   logic          have_data = 1'b1;
   logic [DW-1:0] e1 = '0;
   logic [DW-1:0] e2 = '0;

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          ov;
      logic [DW-1:0] x1;
      logic [DW-1:0] x2;
      logic          cd;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // One clock with in_valid=v; d_in carries the running sequence value.
   task automatic beat(input logic v, input string tag);
      logic          ev;
      logic [DW-1:0] d;
      d = DW'(seq);
      @(negedge clk);
      in_valid = v;
      d_in     = v ? d : 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      ev = v && (since_rst >= 2 * LW);
      if (v) begin
         seq++;
         if (since_rst < 2 * LW) since_rst++;
         if (ev) begin
            e1 = d - LW;
            e2 = d - 2 * LW;
            have_data = 1'b1;
         end else begin
            have_data = 1'b0;
         end
      end
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
      if (have_data) begin
         chk({tag, ".d_out1"}, d_out1, e1);
         chk({tag, ".d_out2"}, d_out2, e2);
      end
   endtask

   initial begin
      for (int k = 0; k < 12; k++) begin
         vecs[k].v  = 1'b1;
         vecs[k].d  = DW'(k);
         vecs[k].ov = (k >= 8);
         vecs[k].x1 = DW'(k - 4);
         vecs[k].x2 = DW'(k - 8);
         vecs[k].cd = (k >= 8);
      end

      // Reset held with in_valid toggling: outputs stay cleared.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = i[0];
         d_in     = DW'(100 + i);
         @(posedge clk);
         #1;
         chk("rst_hold.out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_hold.d_out1", d_out1, 32'd0);
         chk("rst_hold.d_out2", d_out2, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;

      // Continuous stream 0..11 from the table.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         in_valid = vecs[k].v;
         d_in     = vecs[k].d;
         @(posedge clk);
         #1;
         chk($sformatf("cont[%0d].out_valid", k), {31'd0, out_valid}, {31'd0, vecs[k].ov});
         if (vecs[k].cd) begin
            chk($sformatf("cont[%0d].d_out1", k), d_out1, vecs[k].x1);
            chk($sformatf("cont[%0d].d_out2", k), d_out2, vecs[k].x2);
         end
      end
      seq       = 12;
      since_rst = 2 * LW;
      have_data = 1'b1;
      e1        = 32'd7;
      e2        = 32'd3;

      // in_valid toggling every cycle.
      for (int i = 0; i < 16; i++) beat(~i[0], "toggle");

      // Long gap mid-row.
      beat(1'b1, "pregap");
      for (int i = 0; i < 10; i++) beat(1'b0, "gap");
      for (int i = 0; i < 3; i++) beat(1'b1, "postgap");

      // Reset mid-stream after further beats.
      for (int i = 0; i < 12; i++) beat(1'b1, "prerst");
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst.d_out1", d_out1, 32'd0);
      chk("midrst.d_out2", d_out2, 32'd0);
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      since_rst = 0;
      have_data = 1'b1;
      e1        = '0;
      e2        = '0;
      for (int i = 0; i < 12; i++) beat(1'b1, "refill");

      // Steady state.
      for (int i = 0; i < 100; i++) beat(1'b1, "steady");
      chk("steady.col", d_out1, d_out2 + LW);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
